// File: rtl/l2_reqs_sched_pkg.sv
// Shared definitions for the L2 outstanding-request buffer scheduler.
// Buffer op codes, scheduler FSM encoding, grant bit positions and arbitration helpers.
// Optional feature macro used by l2_reqs_sched: L2_REQS_SCHED_RR_EN.
`ifndef N_REQS
`define N_REQS 4
`endif
`ifndef REQS_BITS
`define REQS_BITS 2
`endif

package l2_reqs_sched_pkg;

  // Request-buffer op codes; 0 means no operation on the lookup port.
  localparam logic [2:0] L2_REQS_NOP        = 3'd0;
  localparam logic [2:0] L2_REQS_LOOKUP     = 3'd1;
  localparam logic [2:0] L2_REQS_PEEK_FWD   = 3'd2;
  localparam logic [2:0] L2_REQS_PEEK_REQ   = 3'd3;
  localparam logic [2:0] L2_REQS_PEEK_FLUSH = 3'd4;

  // Scheduler FSM encoding.
  localparam logic [1:0] L2_REQS_SCHED_IDLE  = 2'd0;
  localparam logic [1:0] L2_REQS_SCHED_ISSUE = 2'd1;
  localparam logic [1:0] L2_REQS_SCHED_DONE  = 2'd2;

  // Grant bit positions, grant = {flush, req, fwd, rsp}.
  localparam int L2_REQS_GNT_RSP   = 0;
  localparam int L2_REQS_GNT_FWD   = 1;
  localparam int L2_REQS_GNT_REQ   = 2;
  localparam int L2_REQS_GNT_FLUSH = 3;

  // Fixed-priority pick, lowest bit wins (rsp > fwd > req > flush).
  function automatic logic [3:0] l2_reqs_pick_fixed(input logic [3:0] elig);
    logic [3:0] g;
    g = 4'b0000;
    if (elig[0]) begin
      g = 4'b0001;
    end else if (elig[1]) begin
      g = 4'b0010;
    end else if (elig[2]) begin
      g = 4'b0100;
    end else if (elig[3]) begin
      g = 4'b1000;
    end else begin
      g = 4'b0000;
    end
    return g;
  endfunction

  // Op code to present on the buffer port for a one-hot grant.
  function automatic logic [2:0] l2_reqs_op_of(input logic [3:0] gnt);
    logic [2:0] op;
    case (gnt)
      4'b0001: op = L2_REQS_LOOKUP;
      4'b0010: op = L2_REQS_PEEK_FWD;
      4'b0100: op = L2_REQS_PEEK_REQ;
      4'b1000: op = L2_REQS_PEEK_FLUSH;
      default: op = L2_REQS_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/l2_reqs_cnt.sv
// Occupancy counter for the L2 request buffer.
// Saturates at N_ENTRIES and at zero; any attempt to go past either end
// raises a sticky err that only reset clears.
module l2_reqs_cnt
  import l2_reqs_sched_pkg::*;
#(
  parameter int N_ENTRIES = 4,
  parameter int CW        = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc,
  input  logic          dealloc,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty,
  output logic          err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(N_ENTRIES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_r;
  logic          err_r;

  // Count fills and returns; simultaneous alloc+dealloc leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else if (alloc && !dealloc) begin
      if (cnt_r == CNT_MAX) begin
        err_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else if (dealloc && !alloc) begin
      if (cnt_r == '0) begin
        err_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  assign cnt   = cnt_r;
  assign full  = (cnt_r == CNT_MAX);
  assign empty = (cnt_r == '0);
  assign err   = err_r;

endmodule

// File: rtl/l2_reqs_sched.sv
// Scheduler for the L2 outstanding-request buffer lookup port.
// Arbitrates rsp/fwd/req/flush, drives op code and lookup enable for one
// ISSUE cycle, returns the result in the following DONE cycle, tracks the
// sticky set-conflict / forward-stall flags and the buffer occupancy.
// Optional macro L2_REQS_SCHED_RR_EN: round-robin between fwd and req.
`ifndef N_REQS
`define N_REQS 4
`endif
`ifndef REQS_BITS
`define REQS_BITS 2
`endif

module l2_reqs_sched
  import l2_reqs_sched_pkg::*;
#(
  parameter int N_ENTRIES = `N_REQS,
  parameter int IW        = `REQS_BITS,
  parameter int CW        = `REQS_BITS + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rsp_valid,
  input  logic          fwd_valid,
  input  logic          req_valid,
  input  logic          flush_valid,
  output logic          rsp_ready,
  output logic          fwd_ready,
  output logic          req_ready,
  output logic          flush_ready,
  output logic [3:0]    grant,
  output logic [2:0]    reqs_op_code,
  output logic          lookup_en,
  input  logic          set_set_conflict,
  input  logic          clr_set_conflict,
  input  logic          set_fwd_stall,
  input  logic          clr_fwd_stall,
  input  logic [IW-1:0] reqs_i,
  input  logic          reqs_hit,
  input  logic          alloc,
  input  logic          dealloc,
  output logic          result_valid,
  output logic [IW-1:0] result_i,
  output logic          result_hit,
  output logic          result_conflict,
  output logic [CW-1:0] reqs_cnt,
  output logic          reqs_full,
  output logic          reqs_empty,
  output logic          set_conflict,
  output logic          fwd_stall,
  output logic          err
);

  logic [1:0] state_r;
  logic [1:0] state_nxt;
  logic [3:0] grant_r;
  logic [3:0] grant_nxt;
  logic [3:0] elig;
  logic [3:0] cand;
  logic [3:0] pick;
  logic       set_conflict_r;
  logic       fwd_stall_r;
  logic       conflict_r;
  logic       in_issue;
  logic       in_done;
  logic       full_s;

  assign in_issue = (state_r == L2_REQS_SCHED_ISSUE);
  assign in_done  = (state_r == L2_REQS_SCHED_DONE);

  l2_reqs_cnt #(
    .N_ENTRIES (N_ENTRIES),
    .CW        (CW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .alloc   (alloc),
    .dealloc (dealloc),
    .cnt     (reqs_cnt),
    .full    (full_s),
    .empty   (reqs_empty),
    .err     (err)
  );

  // Eligibility per source; in DONE the completing source is consumed and excluded.
  always_comb begin
    elig = 4'b0000;
    elig[L2_REQS_GNT_RSP]   = rsp_valid;
    elig[L2_REQS_GNT_FWD]   = fwd_valid & ~fwd_stall_r;
    elig[L2_REQS_GNT_REQ]   = req_valid & ~set_conflict_r & ~full_s;
    elig[L2_REQS_GNT_FLUSH] = flush_valid & ~full_s & ~req_valid;
    if (in_done) begin
      cand = elig & ~grant_r;
    end else begin
      cand = elig;
    end
  end

`ifdef L2_REQS_SCHED_RR_EN
  logic rr_fav_req_r;

  // Fixed priority except that fwd and req alternate when both contend.
  always_comb begin
    pick = l2_reqs_pick_fixed(cand);
    if (!cand[L2_REQS_GNT_RSP] && cand[L2_REQS_GNT_FWD] && cand[L2_REQS_GNT_REQ]) begin
      pick = rr_fav_req_r ? 4'b0100 : 4'b0010;
    end else begin
      pick = l2_reqs_pick_fixed(cand);
    end
  end

  // Last-winner pointer: after fwd wins req is favoured next, and vice versa.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_fav_req_r <= 1'b0;
    end else if (state_r != L2_REQS_SCHED_ISSUE) begin
      if (pick[L2_REQS_GNT_FWD]) begin
        rr_fav_req_r <= 1'b1;
      end else if (pick[L2_REQS_GNT_REQ]) begin
        rr_fav_req_r <= 1'b0;
      end
    end
  end
`else
  // Fixed priority rsp > fwd > req > flush.
  always_comb begin
    pick = l2_reqs_pick_fixed(cand);
  end
`endif

  // Next state and grant: arbitrate in IDLE and DONE, hold the grant through ISSUE.
  always_comb begin
    state_nxt = state_r;
    grant_nxt = grant_r;
    case (state_r)
      L2_REQS_SCHED_IDLE, L2_REQS_SCHED_DONE: begin
        if (pick != 4'b0000) begin
          state_nxt = L2_REQS_SCHED_ISSUE;
          grant_nxt = pick;
        end else begin
          state_nxt = L2_REQS_SCHED_IDLE;
          grant_nxt = 4'b0000;
        end
      end
      L2_REQS_SCHED_ISSUE: begin
        state_nxt = L2_REQS_SCHED_DONE;
        grant_nxt = grant_r;
      end
      default: begin
        state_nxt = L2_REQS_SCHED_IDLE;
        grant_nxt = 4'b0000;
      end
    endcase
  end

  // FSM and grant registers; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= L2_REQS_SCHED_IDLE;
      grant_r <= 4'b0000;
    end else begin
      state_r <= state_nxt;
      grant_r <= grant_nxt;
    end
  end

  // Sticky flags updated by the peek result at the end of ISSUE; any dealloc clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_conflict_r <= 1'b0;
      fwd_stall_r    <= 1'b0;
    end else if (dealloc) begin
      set_conflict_r <= 1'b0;
      fwd_stall_r    <= 1'b0;
    end else if (in_issue) begin
      if (grant_r[L2_REQS_GNT_REQ]) begin
        if (clr_set_conflict) begin
          set_conflict_r <= 1'b0;
        end else if (set_set_conflict) begin
          set_conflict_r <= 1'b1;
        end
      end
      if (grant_r[L2_REQS_GNT_FWD]) begin
        if (clr_fwd_stall) begin
          fwd_stall_r <= 1'b0;
        end else if (set_fwd_stall) begin
          fwd_stall_r <= 1'b1;
        end
      end
    end
  end

  // Conflict indication the buffer reported for this op, returned with the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_r <= 1'b0;
    end else if (in_issue) begin
      conflict_r <= (grant_r[L2_REQS_GNT_REQ] & set_set_conflict & ~clr_set_conflict) |
                    (grant_r[L2_REQS_GNT_FWD] & set_fwd_stall & ~clr_fwd_stall);
    end
  end

  assign grant           = grant_r;
  assign reqs_op_code    = in_issue ? l2_reqs_op_of(grant_r) : L2_REQS_NOP;
  assign lookup_en       = in_issue;
  assign rsp_ready       = in_done & grant_r[L2_REQS_GNT_RSP];
  assign fwd_ready       = in_done & grant_r[L2_REQS_GNT_FWD];
  assign req_ready       = in_done & grant_r[L2_REQS_GNT_REQ];
  assign flush_ready     = in_done & grant_r[L2_REQS_GNT_FLUSH];
  assign result_valid    = in_done;
  assign result_i        = in_done ? reqs_i : '0;
  assign result_hit      = in_done & reqs_hit;
  assign result_conflict = in_done & conflict_r;
  assign reqs_full       = full_s;
  assign set_conflict    = set_conflict_r;
  assign fwd_stall       = fwd_stall_r;

endmodule

// File: tb/tb_l2_reqs_sched.sv
// Self-checking bench for l2_reqs_sched (N_ENTRIES=4): directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_l2_reqs_sched;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          rsp_valid, fwd_valid, req_valid, flush_valid;
  logic          rsp_ready, fwd_ready, req_ready, flush_ready;
  logic [3:0]    grant;
  logic [2:0]    reqs_op_code;
  logic          lookup_en;
  logic          set_set_conflict, clr_set_conflict, set_fwd_stall, clr_fwd_stall;
  logic [IW-1:0] reqs_i;
  logic          reqs_hit;
  logic          alloc, dealloc;
  logic          result_valid;
  logic [IW-1:0] result_i;
  logic          result_hit, result_conflict;
  logic [CW-1:0] reqs_cnt;
  logic          reqs_full, reqs_empty, set_conflict, fwd_stall, err;

  l2_reqs_sched #(.N_ENTRIES(N), .IW(IW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .rsp_valid(rsp_valid), .fwd_valid(fwd_valid), .req_valid(req_valid), .flush_valid(flush_valid),
    .rsp_ready(rsp_ready), .fwd_ready(fwd_ready), .req_ready(req_ready), .flush_ready(flush_ready),
    .grant(grant), .reqs_op_code(reqs_op_code), .lookup_en(lookup_en),
    .set_set_conflict(set_set_conflict), .clr_set_conflict(clr_set_conflict),
    .set_fwd_stall(set_fwd_stall), .clr_fwd_stall(clr_fwd_stall),
    .reqs_i(reqs_i), .reqs_hit(reqs_hit), .alloc(alloc), .dealloc(dealloc),
    .result_valid(result_valid), .result_i(result_i), .result_hit(result_hit),
    .result_conflict(result_conflict), .reqs_cnt(reqs_cnt), .reqs_full(reqs_full),
    .reqs_empty(reqs_empty), .set_conflict(set_conflict), .fwd_stall(fwd_stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: phase 0 = no op, 1 = op being issued, 2 = result returning.
  int m_phase, m_src, m_cnt;
  bit m_err, m_sc, m_fs, m_conf, m_rr;
  logic [2:0] opc [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    logic [3:0] er;
    eg = 4'b0000;
    er = 4'b0000;
    if (m_phase != 0) eg[m_src] = 1'b1;
    if (m_phase == 2) er[m_src] = 1'b1;
    chk("grant",        32'(grant), 32'(eg));
    chk("op_code",      32'(reqs_op_code), (m_phase == 1) ? 32'(opc[m_src]) : 32'd0);
    chk("lookup_en",    32'(lookup_en), (m_phase == 1) ? 32'd1 : 32'd0);
    chk("ready",        32'({flush_ready, req_ready, fwd_ready, rsp_ready}), 32'(er));
    chk("result_valid", 32'(result_valid), (m_phase == 2) ? 32'd1 : 32'd0);
    chk("result_i",     32'(result_i), (m_phase == 2) ? 32'(reqs_i) : 32'd0);
    chk("result_hit",   32'(result_hit), (m_phase == 2) ? 32'(reqs_hit) : 32'd0);
    chk("result_conflict", 32'(result_conflict), (m_phase == 2) ? 32'(m_conf) : 32'd0);
    chk("reqs_cnt",     32'(reqs_cnt), 32'(m_cnt));
    chk("reqs_full",    32'(reqs_full), (m_cnt == N) ? 32'd1 : 32'd0);
    chk("reqs_empty",   32'(reqs_empty), (m_cnt == 0) ? 32'd1 : 32'd0);
    chk("set_conflict", 32'(set_conflict), 32'(m_sc));
    chk("fwd_stall",    32'(fwd_stall), 32'(m_fs));
    chk("err",          32'(err), 32'(m_err));
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    bit e [4];
    int win;
    bit full;
    if (rst) begin
      m_phase = 0; m_src = 0; m_cnt = 0; m_err = 0;
      m_sc = 0; m_fs = 0; m_conf = 0; m_rr = 0;
      return;
    end
    full = (m_cnt == N);
    e[0] = rsp_valid;
    e[1] = fwd_valid && !m_fs;
    e[2] = req_valid && !m_sc && !full;
    e[3] = flush_valid && !full && !req_valid;
    if (m_phase == 2) e[m_src] = 0;
    win = -1;
    for (int i = 3; i >= 0; i--) if (e[i]) win = i;
`ifdef L2_REQS_SCHED_RR_EN
    if (win == 1 && e[2] && m_rr) win = 2;
`endif
    if (m_phase == 1) begin
      m_phase = 2;
      m_conf = (m_src == 2 && set_set_conflict && !clr_set_conflict) ||
               (m_src == 1 && set_fwd_stall && !clr_fwd_stall);
      if (m_src == 2) m_sc = clr_set_conflict ? 1'b0 : (set_set_conflict ? 1'b1 : m_sc);
      if (m_src == 1) m_fs = clr_fwd_stall ? 1'b0 : (set_fwd_stall ? 1'b1 : m_fs);
    end else if (win >= 0) begin
      m_phase = 1;
      m_src = win;
      if (win == 1) m_rr = 1;
      if (win == 2) m_rr = 0;
    end else begin
      m_phase = 0;
    end
    if (dealloc) begin
      m_sc = 0;
      m_fs = 0;
    end
    if (alloc && !dealloc) begin
      if (m_cnt == N) m_err = 1; else m_cnt++;
    end else if (dealloc && !alloc) begin
      if (m_cnt == 0) m_err = 1; else m_cnt--;
    end
  endtask

  // One clock: compare present outputs, advance model, move to next negedge.
  task automatic cycle();
    #1;
    compare_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst = 1'b0;
    rsp_valid = 1'b0; fwd_valid = 1'b0; req_valid = 1'b0; flush_valid = 1'b0;
    set_set_conflict = 1'b0; clr_set_conflict = 1'b0;
    set_fwd_stall = 1'b0; clr_fwd_stall = 1'b0;
    reqs_i = '0; reqs_hit = 1'b0; alloc = 1'b0; dealloc = 1'b0;
  endtask

  task automatic rand_inputs();
    rst              = ($urandom_range(0, 299) == 0);
    rsp_valid        = ($urandom_range(0, 3) == 0);
    fwd_valid        = ($urandom_range(0, 1) == 0);
    req_valid        = ($urandom_range(0, 1) == 0);
    flush_valid      = ($urandom_range(0, 2) == 0);
    set_set_conflict = ($urandom_range(0, 3) == 0);
    clr_set_conflict = ($urandom_range(0, 3) == 0);
    set_fwd_stall    = ($urandom_range(0, 3) == 0);
    clr_fwd_stall    = ($urandom_range(0, 3) == 0);
    reqs_i           = IW'($urandom_range(0, 3));
    reqs_hit         = 1'($urandom_range(0, 1));
    alloc            = ($urandom_range(0, 9) < 3);
    dealloc          = ($urandom_range(0, 9) < 3);
  endtask

  initial begin
    opc[0] = 3'd1; opc[1] = 3'd2; opc[2] = 3'd3; opc[3] = 3'd4;
    clear_inputs();
    rst = 1'b1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_empty", 32'(reqs_empty), 32'd1);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_cnt",   32'(reqs_cnt), 32'd0);

    // rsp alone: LOOKUP in ISSUE, ready with buffer index in DONE
    rsp_valid = 1'b1; reqs_i = 2'd2;
    cycle();
    chk("t1_op",     32'(reqs_op_code), 32'd1);
    chk("t1_lookup", 32'(lookup_en), 32'd1);
    cycle();
    chk("t1_ready",  32'(rsp_ready), 32'd1);
    chk("t1_res_i",  32'(result_i), 32'd2);
    rsp_valid = 1'b0;
    cycle();

    // rsp, fwd, req together: grants on cycles 1, 3, 5
    rsp_valid = 1'b1; fwd_valid = 1'b1; req_valid = 1'b1;
    cycle();
    chk("t2_g1", 32'(grant), 32'h1);
    cycle();
    cycle();
    chk("t2_g3", 32'(grant), 32'h2);
    rsp_valid = 1'b0;
    cycle();
    cycle();
    chk("t2_g5", 32'(grant), 32'h4);
    fwd_valid = 1'b0;
    cycle();
    cycle();
    req_valid = 1'b0;

    // Set conflict on PEEK_REQ blocks the next req until a dealloc
    alloc = 1'b1;
    cycle();
    alloc = 1'b0;
    req_valid = 1'b1;
    cycle();
    set_set_conflict = 1'b1;
    cycle();
    chk("t3_ready", 32'(req_ready), 32'd1);
    chk("t3_rconf", 32'(result_conflict), 32'd1);
    chk("t3_sc",    32'(set_conflict), 32'd1);
    set_set_conflict = 1'b0;
    cycle();
    cycle();
    chk("t3_blocked", 32'(grant), 32'd0);
    dealloc = 1'b1;
    cycle();
    chk("t3_sc_clr", 32'(set_conflict), 32'd0);
    dealloc = 1'b0;
    cycle();
    chk("t3_reissue", 32'(grant), 32'h4);
    cycle();
    req_valid = 1'b0;
    cycle();

    // Fill to full; req and flush held off; alloc+dealloc keeps count
    alloc = 1'b1;
    repeat (4) cycle();
    alloc = 1'b0;
    chk("t4_full", 32'(reqs_full), 32'd1);
    chk("t4_cnt4", 32'(reqs_cnt), 32'd4);
    flush_valid = 1'b1;
    cycle();
    cycle();
    chk("t4_no_flush", 32'(grant), 32'd0);
    flush_valid = 1'b0; req_valid = 1'b1;
    cycle();
    cycle();
    chk("t4_no_req", 32'(grant), 32'd0);
    alloc = 1'b1; dealloc = 1'b1;
    cycle();
    chk("t4_both", 32'(reqs_cnt), 32'd4);
    alloc = 1'b0;
    cycle();
    chk("t4_cnt3", 32'(reqs_cnt), 32'd3);
    dealloc = 1'b0;
    cycle();
    chk("t4_req_g", 32'(grant), 32'h4);
    cycle();
    req_valid = 1'b0;
    cycle();

    // Underflow sets err; reset clears it
    rst = 1'b1;
    cycle();
    rst = 1'b0; dealloc = 1'b1;
    cycle();
    dealloc = 1'b0;
    chk("t5_cnt0", 32'(reqs_cnt), 32'd0);
    chk("t5_err",  32'(err), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_err_clr", 32'(err), 32'd0);
    chk("t5_empty",   32'(reqs_empty), 32'd1);

    // Reset during ISSUE of a fwd op abandons it
    fwd_valid = 1'b1;
    cycle();
    chk("t6_fwd_g", 32'(grant), 32'h2);
    set_fwd_stall = 1'b1; rst = 1'b1;
    cycle();
    chk("t6_no_ready", 32'(fwd_ready), 32'd0);
    chk("t6_grant0",   32'(grant), 32'd0);
    chk("t6_stall0",   32'(fwd_stall), 32'd0);
    rst = 1'b0; set_fwd_stall = 1'b0; fwd_valid = 1'b0;
    cycle();
    chk("t6_idle", 32'(lookup_en), 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rand_inputs();
      cycle();
    end
    clear_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
